// File: rtl/dwc_result_sequencer.sv
// Initiator for a duplicate-with-compare checker: captures one word per core, arms and triggers
// the checker, commits agreed results, retries mismatches. Optional skew watchdog: DWC_SKEW_WATCHDOG_EN.
module dwc_result_sequencer #(
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int SKEW_CYC    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_a_valid,
    input  logic [31:0] core_a_data,
    output logic        core_a_ready,
    input  logic        core_b_valid,
    input  logic [31:0] core_b_data,
    output logic        core_b_ready,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic [31:0] data_set,
    output logic        chk_reset,
    input  logic [31:0] is_match,
    input  logic        interupt_match,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        rerun_req,
    output logic [3:0]  retry_count,
    output logic        fault,
    output logic [1:0]  fault_code,
    input  logic        fault_clr
);
    typedef enum logic [2:0] {S_CAPTURE, S_ARM, S_TRIG, S_DECIDE, S_COMMIT, S_FAULT} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t          state, state_nx;
    logic            cap_a, cap_b, cap_a_nx, cap_b_nx;
    logic            arm_cnt;
    logic [TW-1:0]   timer;
    logic            match_q;
    logic            cap_a_fire, cap_b_fire, cap_a_now, cap_b_now;

    logic            core_a_ready_nx, core_b_ready_nx, chk_reset_nx, res_valid_nx;
    logic            rerun_req_nx, fault_nx;
    logic [31:0]     data_a_nx, data_b_nx, data_set_nx, res_data_nx;
    logic [3:0]      retry_count_nx;
    logic [1:0]      fault_code_nx;

    logic            unused_match_bits;
    assign unused_match_bits = ^is_match[31:1];

`ifdef DWC_SKEW_WATCHDOG_EN
    localparam int SW = $clog2(SKEW_CYC);
    localparam logic [SW-1:0] SKEW_LAST = SW'(SKEW_CYC - 1);
    logic [SW-1:0] skew_cnt;
`else
    logic [31:0] unused_skew;
    assign unused_skew = 32'(SKEW_CYC);
`endif

    assign cap_a_fire = (state == S_CAPTURE) && core_a_valid && core_a_ready;
    assign cap_b_fire = (state == S_CAPTURE) && core_b_valid && core_b_ready;
    assign cap_a_now  = cap_a | cap_a_fire;
    assign cap_b_now  = cap_b | cap_b_fire;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_CAPTURE;
        else        state <= state_nx;
    end

    // next-state logic; a capture or interrupt beats an expiry landing in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            S_CAPTURE: begin
                if (cap_a_now && cap_b_now) state_nx = S_ARM;
`ifdef DWC_SKEW_WATCHDOG_EN
                else if ((cap_a ^ cap_b) && skew_cnt == SKEW_LAST) state_nx = S_FAULT;
`endif
            end
            S_ARM:    if (arm_cnt) state_nx = S_TRIG;
            S_TRIG: begin
                if (interupt_match)        state_nx = S_DECIDE;
                else if (timer == TMO_LAST) state_nx = S_FAULT;
            end
            S_DECIDE: begin
                if (match_q)                          state_nx = S_COMMIT;
                else if (retry_count < 4'(MAX_RETRY)) state_nx = S_CAPTURE;
                else                                  state_nx = S_FAULT;
            end
            S_COMMIT: if (res_ready) state_nx = S_CAPTURE;
            S_FAULT:  if (fault_clr) state_nx = S_CAPTURE;
            default:  state_nx = S_CAPTURE;
        endcase
    end

    // next values of the registered outputs, derived from the state being entered
    always_comb begin
        cap_a_nx        = (state == S_CAPTURE && state_nx == S_CAPTURE) ? cap_a_now : 1'b0;
        cap_b_nx        = (state == S_CAPTURE && state_nx == S_CAPTURE) ? cap_b_now : 1'b0;
        core_a_ready_nx = (state_nx == S_CAPTURE) && !cap_a_nx;
        core_b_ready_nx = (state_nx == S_CAPTURE) && !cap_b_nx;
        data_a_nx       = cap_a_fire ? core_a_data : data_a;
        data_b_nx       = cap_b_fire ? core_b_data : data_b;
        data_set_nx     = (state_nx == S_TRIG) ? 32'd3 : 32'd0;
        // checker held in re-arm except while a compare is in flight or its verdict is in use
        chk_reset_nx    = !(state_nx == S_TRIG || state_nx == S_DECIDE || state_nx == S_COMMIT);
        res_valid_nx    = (state_nx == S_COMMIT);
        res_data_nx     = (state == S_DECIDE && state_nx == S_COMMIT) ? data_a : res_data;
        rerun_req_nx    = (state == S_DECIDE && state_nx == S_CAPTURE);
        retry_count_nx  = retry_count;
        if (rerun_req_nx)
            retry_count_nx = retry_count + 4'd1;
        else if ((state == S_COMMIT || state == S_FAULT) && state_nx == S_CAPTURE)
            retry_count_nx = 4'd0;
        fault_nx        = (state_nx == S_FAULT);
        fault_code_nx   = 2'b00;
        if (state_nx == S_FAULT) begin
            if (state == S_FAULT)       fault_code_nx = fault_code;
            else if (state == S_TRIG)   fault_code_nx = 2'b01;
            else if (state == S_DECIDE) fault_code_nx = 2'b10;
            else                        fault_code_nx = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_a        <= 1'b0;
            cap_b        <= 1'b0;
            arm_cnt      <= 1'b0;
            timer        <= '0;
            match_q      <= 1'b0;
            core_a_ready <= 1'b0;
            core_b_ready <= 1'b0;
            data_a       <= '0;
            data_b       <= '0;
            data_set     <= '0;
            chk_reset    <= 1'b1;
            res_valid    <= 1'b0;
            res_data     <= '0;
            rerun_req    <= 1'b0;
            retry_count  <= '0;
            fault        <= 1'b0;
            fault_code   <= 2'b00;
        end else begin
            cap_a        <= cap_a_nx;
            cap_b        <= cap_b_nx;
            arm_cnt      <= (state == S_ARM) ? ~arm_cnt : 1'b0;
            timer        <= (state == S_TRIG) ? timer + TW'(1) : '0;
            if (state == S_TRIG && interupt_match) match_q <= is_match[0];
            core_a_ready <= core_a_ready_nx;
            core_b_ready <= core_b_ready_nx;
            data_a       <= data_a_nx;
            data_b       <= data_b_nx;
            data_set     <= data_set_nx;
            chk_reset    <= chk_reset_nx;
            res_valid    <= res_valid_nx;
            res_data     <= res_data_nx;
            rerun_req    <= rerun_req_nx;
            retry_count  <= retry_count_nx;
            fault        <= fault_nx;
            fault_code   <= fault_code_nx;
        end
    end

`ifdef DWC_SKEW_WATCHDOG_EN
    // counts cycles since the first word of a pair was captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                skew_cnt <= '0;
        else if (state == S_CAPTURE && (cap_a ^ cap_b)) skew_cnt <= skew_cnt + SW'(1);
        else                                       skew_cnt <= '0;
    end
`endif

endmodule

// File: tb/tb_dwc_result_sequencer.sv
// Directed bench for dwc_result_sequencer; skew checks follow DWC_SKEW_WATCHDOG_EN.
module tb_dwc_result_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_a_valid, core_b_valid;
    logic [31:0] core_a_data, core_b_data;
    logic        core_a_ready, core_b_ready;
    logic [31:0] data_a, data_b, data_set;
    logic        chk_reset;
    logic [31:0] is_match;
    logic        interupt_match;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        rerun_req;
    logic [3:0]  retry_count;
    logic        fault;
    logic [1:0]  fault_code;
    logic        fault_clr;

    int vectors = 0;
    int errs    = 0;

    dwc_result_sequencer dut (
        .clk(clk), .reset(reset),
        .core_a_valid(core_a_valid), .core_a_data(core_a_data), .core_a_ready(core_a_ready),
        .core_b_valid(core_b_valid), .core_b_data(core_b_data), .core_b_ready(core_b_ready),
        .data_a(data_a), .data_b(data_b), .data_set(data_set), .chk_reset(chk_reset),
        .is_match(is_match), .interupt_match(interupt_match),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .rerun_req(rerun_req), .retry_count(retry_count),
        .fault(fault), .fault_code(fault_code), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // capture a pair, walk ARM, answer the trigger; returns just after the DECIDE edge
    task automatic do_compare(input logic [31:0] a, input logic [31:0] b, input logic m);
        core_a_valid = 1'b1; core_a_data = a;
        core_b_valid = 1'b1; core_b_data = b;
        tick();
        core_a_valid = 1'b0; core_b_valid = 1'b0;
        tick();
        tick();
        chk("cmp_trig", data_set, 32'd3);
        interupt_match = 1'b1;
        is_match = {31'h7FFF_FFFF, m};
        tick();
        interupt_match = 1'b0;
        is_match = 32'd0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        core_a_valid = 1'b0; core_a_data = '0;
        core_b_valid = 1'b0; core_b_data = '0;
        is_match = '0; interupt_match = 1'b0;
        res_ready = 1'b0; fault_clr = 1'b0;

        repeat (2) tick();
        chk("rst_ready_a", core_a_ready, 0);
        chk("rst_chk_reset", chk_reset, 1);
        chk("rst_data_set", data_set, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_fault", {fault, fault_code}, 0);
        chk("rst_retry", retry_count, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", {core_a_ready, core_b_ready}, 2'b11);

        // 1: simultaneous identical words
        core_a_valid = 1'b1; core_a_data = 32'hDEADBEEF;
        core_b_valid = 1'b1; core_b_data = 32'hDEADBEEF;
        tick();
        core_a_valid = 1'b0; core_b_valid = 1'b0;
        chk("t1_data_a", data_a, 32'hDEADBEEF);
        chk("t1_ready_off", {core_a_ready, core_b_ready}, 2'b00);
        chk("t1_arm1_ds", data_set, 0);
        chk("t1_arm1_cr", chk_reset, 1);
        tick();
        chk("t1_arm2_ds", data_set, 0);
        chk("t1_arm2_cr", chk_reset, 1);
        tick();
        chk("t1_trig_ds", data_set, 32'd3);
        chk("t1_trig_cr", chk_reset, 0);
        interupt_match = 1'b1; is_match = 32'd1;
        tick();
        interupt_match = 1'b0; is_match = 32'd0;
        chk("t1_ds_drop", data_set, 0);
        tick();
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_data", res_data, 32'hDEADBEEF);
        chk("t1_retry", retry_count, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_accept", {res_valid, core_a_ready, core_b_ready}, 3'b011);

        // 2: skewed arrival, commit back-pressured
        core_a_valid = 1'b1; core_a_data = 32'd5;
        tick();
        core_a_valid = 1'b0;
        chk("t2_ready_a", {core_a_ready, core_b_ready}, 2'b01);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("t2_clr_ignored", {core_a_ready, fault}, 2'b00);
        tick(); tick();
        core_b_valid = 1'b1; core_b_data = 32'd5;
        tick();
        core_b_valid = 1'b0;
        chk("t2_data_b", data_b, 32'd5);
        tick(); tick();
        chk("t2_trig", data_set, 32'd3);
        interupt_match = 1'b1; is_match = 32'd1;
        tick();
        interupt_match = 1'b0;
        tick();
        chk("t2_res", {res_valid, res_data}, {1'b1, 32'd5});
        tick(); tick();
        chk("t2_hold", {res_valid, res_data}, {1'b1, 32'd5});
        chk("t2_no_ready", {core_a_ready, core_b_ready}, 2'b00);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t2_accept", {res_valid, core_a_ready, core_b_ready}, 3'b011);

        // 3: repeated mismatch exhausts retries
        for (int i = 1; i <= 3; i++) begin
            do_compare(32'd1, 32'd2, 1'b0);
            chk("t3_rerun", rerun_req, 1);
            chk("t3_retry", retry_count, 32'(i));
            chk("t3_fault", fault, 0);
        end
        do_compare(32'd1, 32'd2, 1'b0);
        chk("t3_rerun_last", rerun_req, 0);
        chk("t3_fault_code", {fault, fault_code}, 3'b110);
        chk("t3_retry_hold", retry_count, 3);
        chk("t3_fault_cr", chk_reset, 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("t3_clr", {fault, fault_code, retry_count}, 7'd0);
        chk("t3_clr_ready", {core_a_ready, core_b_ready}, 2'b11);

        // 4: interrupt withheld -> timeout after 16 TRIG cycles
        core_a_valid = 1'b1; core_a_data = 32'd7;
        core_b_valid = 1'b1; core_b_data = 32'd7;
        tick();
        core_a_valid = 1'b0; core_b_valid = 1'b0;
        tick(); tick();
        chk("t4_trig", data_set, 32'd3);
        repeat (15) tick();
        chk("t4_not_yet", fault, 0);
        tick();
        chk("t4_timeout", {fault, fault_code}, 3'b101);
        chk("t4_ds", data_set, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("t4_clr", {fault, fault_code, core_a_ready}, 4'b0001);

        // 4b: interrupt on the last timer cycle wins
        core_a_valid = 1'b1; core_b_valid = 1'b1;
        tick();
        core_a_valid = 1'b0; core_b_valid = 1'b0;
        tick(); tick();
        repeat (15) tick();
        interupt_match = 1'b1; is_match = 32'd1;
        tick();
        interupt_match = 1'b0;
        chk("t4b_no_fault", {fault, data_set}, 33'd0);
        tick();
        chk("t4b_commit", {res_valid, res_data}, {1'b1, 32'd7});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // 5: asynchronous reset in TRIG
        core_a_valid = 1'b1; core_a_data = 32'd3;
        core_b_valid = 1'b1; core_b_data = 32'd3;
        tick();
        core_a_valid = 1'b0; core_b_valid = 1'b0;
        tick(); tick();
        chk("t5_trig", data_set, 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_ds", data_set, 0);
        chk("t5_rst_cr", chk_reset, 1);
        chk("t5_rst_data", {data_a, res_data}, 64'd0);
        chk("t5_rst_ready", {core_a_ready, core_b_ready, res_valid}, 3'b000);
        reset = 1'b1;
        tick();
        chk("t5_rel_cr", chk_reset, 1);
        core_a_valid = 1'b1; core_b_valid = 1'b1;
        tick();
        core_a_valid = 1'b0; core_b_valid = 1'b0;
        chk("t5_arm1_cr", chk_reset, 1);
        tick();
        chk("t5_arm2_cr", chk_reset, 1);
        tick();
        chk("t5_trig_cr", chk_reset, 0);
        interupt_match = 1'b1; is_match = 32'd1;
        tick();
        interupt_match = 1'b0;
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // 6: only core A produces a word
        core_a_valid = 1'b1; core_a_data = 32'd9;
        tick();
`ifdef DWC_SKEW_WATCHDOG_EN
        repeat (31) tick();
        chk("t6_not_yet", fault, 0);
        tick();
        chk("t6_skew", {fault, fault_code}, 3'b111);
        core_a_valid = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("t6_clr", {fault, core_a_ready, core_b_ready}, 3'b011);
`else
        repeat (40) tick();
        chk("t6_no_fault", {fault, fault_code}, 3'b000);
        chk("t6_wait_b", {core_a_ready, core_b_ready}, 2'b01);
        core_a_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
